// File: rtl/serial_subtractor_pkg.sv
// Shared arithmetic definitions for the bit-serial subtractor family.
package serial_subtractor_pkg;

  // Sequencer states of the serial subtractor.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Default operand width when no override is given.
  localparam int DEFAULT_WIDTH = 4;

endpackage

// File: rtl/serial_subtractor_fullsubtractor.sv
// One-bit full subtractor: d = x - y - bin, bout set when the bit underflows.
// Kept standalone so a future parallel subtractor can ripple copies of it.
module fullsubtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  // Difference bit and borrow generation/propagation.
  always_comb begin
    d    = x ^ y ^ bin;
    bout = (~x & y) | (~(x ^ y) & bin);
  end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin (mod 2^WIDTH), one bit per clock,
// LSB first, through a single full-subtractor cell and a borrow flop.
//
// Handshake: a start seen high at a rising edge while the block is in IDLE or
// DONE is accepted and captures a, b and bin; start is ignored in RUN. Exactly
// WIDTH edges later done pulses high for one cycle, and diff/bout are valid
// from that edge and hold until the next completion or reset. busy is high for
// the whole RUN phase and never overlaps done.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             busy,
  output logic             done
);

  localparam int             CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] work;
  logic             br;
  logic [CW-1:0]    cnt;
  logic             d;
  logic             br_next;
  logic             load;
  logic             last_bit;

  fullsubtractor u_fs (
    .x    (a_sh[0]),
    .y    (b_sh[0]),
    .bin  (br),
    .d    (d),
    .bout (br_next)
  );

  // Next-state decode: accept start only outside RUN, finish on the last bit.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    last_bit   = (state == RUN) && (cnt == LAST);
    case (state)
      IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (last_bit) state_next = DONE;
      end
      DONE: begin
        if (start) begin
          load       = 1'b1;
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Operand shifters, borrow flop, bit counter and working result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh <= '0;
      b_sh <= '0;
      br   <= 1'b0;
      cnt  <= '0;
      work <= '0;
    end else if (load) begin
      a_sh <= a;
      b_sh <= b;
      br   <= bin;
      cnt  <= '0;
      work <= '0;
    end else if (state == RUN) begin
      a_sh <= a_sh >> 1;
      b_sh <= b_sh >> 1;
      br   <= br_next;
      cnt  <= cnt + CW'(1);
      work <= {d, work[WIDTH-1:1]};
    end
  end

  // Registered outputs; the result is published only when the last bit lands,
  // so a run cut short by reset never becomes visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      diff <= '0;
      bout <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      if (last_bit) begin
        diff <= {d, work[WIDTH-1:1]};
        bout <= br_next;
      end
      busy <= (state_next == RUN);
      done <= (state_next == DONE);
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=4 main instance, WIDTH=8 spot check).
module tb_serial_subtractor;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic [W-1:0] diff;
  logic         bout;
  logic         busy;
  logic         done;

  logic         start8;
  logic [7:0]   a8;
  logic [7:0]   b8;
  logic         bin8;
  logic [7:0]   diff8;
  logic         bout8;
  logic         busy8;
  logic         done8;

  int n_cmp;
  int n_bad;
  int cyc;

  // Expected {bout, diff} and the edge number at which done must be seen.
  logic [W:0] exp_q[$];
  int         exp_cyc_q[$];

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .diff  (diff),
    .bout  (bout),
    .busy  (busy),
    .done  (done)
  );

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start8),
    .a     (a8),
    .b     (b8),
    .bin   (bin8),
    .diff  (diff8),
    .bout  (bout8),
    .busy  (busy8),
    .done  (done8)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Rising-edge counter: at a falling edge, cyc is the number of the edge just passed.
  initial cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- checking helper ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [W:0] ref_sub(input int av, input int bv, input int cv);
    int r;
    r = av - bv - cv;
    return {(r < 0) ? 1'b1 : 1'b0, W'(r & ((1 << W) - 1))};
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (busy && done) check("busy_done_overlap", 32'(busy & done), 0);
      if (done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          logic [W:0] e;
          int         ec;
          e  = exp_q.pop_front();
          ec = exp_cyc_q.pop_front();
          check("result", 32'({bout, diff}), 32'(e));
          check("done_cycle", 32'(cyc), 32'(ec));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // One operation with a single-cycle start pulse; returns once done is visible.
  task automatic do_op(input int av, input int bv, input int cv);
    int e_acc;
    @(negedge clk);
    start = 1'b1;
    a     = W'(av);
    b     = W'(bv);
    bin   = cv[0];
    @(negedge clk);
    e_acc = cyc;
    exp_q.push_back(ref_sub(av, bv, cv));
    exp_cyc_q.push_back(e_acc + W);
    start = 1'b0;
    a     = W'($urandom);
    b     = W'($urandom);
    bin   = 1'($urandom);
    check("busy_after_accept", 32'(busy), 1);
    repeat (W) @(negedge clk);
    check("busy_at_done", 32'(busy), 0);
  endtask

  // One operation during which start is re-pulsed with other operands mid-RUN.
  task automatic do_op_ignored(input int av, input int bv, input int cv);
    int e_acc;
    @(negedge clk);
    start = 1'b1;
    a     = W'(av);
    b     = W'(bv);
    bin   = cv[0];
    @(negedge clk);
    e_acc = cyc;
    exp_q.push_back(ref_sub(av, bv, cv));
    exp_cyc_q.push_back(e_acc + W);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    a     = W'(av + 1 + int'($urandom_range(0, 13)));
    b     = W'(bv + 3);
    bin   = ~cv[0];
    @(negedge clk);
    start = 1'b0;
    repeat (W - 2) @(negedge clk);
    check("ignored_busy_at_done", 32'(busy), 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int e_acc;
    int waited;
    n_cmp  = 0;
    n_bad  = 0;
    rst_n  = 1'b0;
    start  = 1'b0;
    a      = '0;
    b      = '0;
    bin    = 1'b0;
    start8 = 1'b0;
    a8     = '0;
    b8     = '0;
    bin8   = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_diff", 32'(diff), 0);
    check("rst_bout", 32'(bout), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases.
    do_op(9, 4, 0);
    do_op(4, 9, 0);
    do_op(0, 0, 1);
    do_op(15, 15, 0);

    // Start re-pulsed during RUN must be ignored.
    do_op_ignored(6, 2, 0);
    do_op_ignored(1, 7, 1);

    // Reset two cycles into RUN: outputs clear at once, no done follows.
    @(negedge clk);
    start = 1'b1;
    a     = 4'd12;
    b     = 4'd5;
    bin   = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrun_rst_diff", 32'(diff), 0);
    check("midrun_rst_bout", 32'(bout), 0);
    check("midrun_rst_busy", 32'(busy), 0);
    check("midrun_rst_done", 32'(done), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (W + 2) @(negedge clk);
    do_op(10, 3, 1);

    // Start held across DONE: the second run is accepted on the edge after
    // the first done, so its done follows WIDTH edges after that accept.
    @(negedge clk);
    start = 1'b1;
    a     = 4'd9;
    b     = 4'd4;
    bin   = 1'b0;
    @(negedge clk);
    e_acc = cyc;
    exp_q.push_back(ref_sub(9, 4, 0));
    exp_cyc_q.push_back(e_acc + W);
    a = 4'd3;
    b = 4'd1;
    exp_q.push_back(ref_sub(3, 1, 0));
    exp_cyc_q.push_back(e_acc + W + 1 + W);
    repeat (W + 1) @(negedge clk);
    start = 1'b0;
    check("b2b_busy", 32'(busy), 1);
    repeat (W) @(negedge clk);
    check("b2b_diff", 32'(diff), 2);

    // Exhaustive sweep of every a, b, bin.
    for (int i = 0; i < (1 << W); i++)
      for (int j = 0; j < (1 << W); j++)
        for (int k = 0; k < 2; k++)
          do_op(i, j, k);

    // Random operations with random idle gaps.
    for (int n = 0; n < 60; n++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      do_op(int'($urandom_range(0, (1 << W) - 1)), int'($urandom_range(0, (1 << W) - 1)),
            int'($urandom_range(0, 1)));
    end

    // WIDTH=8 spot check: 0 - 1 wraps to all ones with a borrow.
    @(negedge clk);
    start8 = 1'b1;
    a8     = 8'h00;
    b8     = 8'h01;
    bin8   = 1'b0;
    @(negedge clk);
    e_acc  = cyc;
    start8 = 1'b0;
    waited = 0;
    while (!done8 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check("w8_done_seen", 32'(done8), 1);
    check("w8_latency", 32'(cyc - e_acc), 8);
    check("w8_diff", 32'(diff8), 32'h0000_00ff);
    check("w8_bout", 32'(bout8), 1);

    repeat (W + 2) @(negedge clk);
    check("pending_results", 32'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
